// File: rtl/gp_register_bank_pkg.sv
// Shared widths and slot constants for the general-purpose register bank.
package gp_register_bank_pkg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned NREGS  = 16;
   localparam int unsigned SEL_W  = 4;

   localparam int unsigned R0_IDX  = 0;
   localparam int unsigned R15_IDX = 15;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [NREGS-1:0] reg_mask_t;
   typedef logic [SEL_W-1:0] sel_t;

endpackage : gp_register_bank_pkg

// File: rtl/gp_register_bank_drive_select_encoder.sv
// 16-to-4 priority encoder for the register drive requests.
// Lowest set index wins; flags whether any and whether several bits are set.
module gp_register_bank_drive_select_encoder
   import gp_register_bank_pkg::*;
(
   input  logic [NREGS-1:0] req_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             valid_o,
   output logic             multi_o
);

   // Scan from the top down so the lowest requesting index is the last written.
   always_comb begin
      sel_o = '0;
      for (int i = int'(NREGS) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            sel_o = SEL_W'(i);
         end
      end
   end

   // Any request, and more than one request (clearing the lowest bit leaves something).
   always_comb begin
      valid_o = |req_i;
      multi_o = |(req_i & (req_i - NREGS'(1)));
   end

endmodule : gp_register_bank_drive_select_encoder

// File: rtl/gp_register_bank.sv
// Sixteen-entry general-purpose register bank feeding the 16-to-1 bus mux.
// Loads any subset of R0..R15 from the bus, exposes all slots flattened,
// and turns one-hot drive requests into the mux select with hold and
// sticky conflict detection.
module gp_register_bank
   import gp_register_bank_pkg::*;
(
   input  logic                   clock,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       bus_in,
   input  logic [NREGS-1:0]       reg_in,
   input  logic [NREGS-1:0]       reg_out,
   input  logic                   ba_out,
   output logic [NREGS*WIDTH-1:0] regs_q,
   output logic [SEL_W-1:0]       select,
   output logic                   select_valid,
   output logic                   select_error
);

   word_t            reg_file_q [NREGS];
   word_t            reg_file_d [NREGS];
   logic [SEL_W-1:0] last_sel_q;
   logic [SEL_W-1:0] last_sel_d;
   logic             error_q;
   logic             error_d;

   logic [SEL_W-1:0] enc_sel;
   logic             enc_valid;
   logic             enc_multi;

   gp_register_bank_drive_select_encoder u_enc (
      .req_i   (reg_out),
      .sel_o   (enc_sel),
      .valid_o (enc_valid),
      .multi_o (enc_multi)
   );

   // Next state: enabled registers take the bus, select index and error tracking.
   always_comb begin
      reg_file_d = reg_file_q;
      last_sel_d = last_sel_q;
      error_d    = error_q;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (reg_in[i]) begin
            reg_file_d[i] = bus_in;
         end
      end
      if (enc_valid) begin
         last_sel_d = enc_sel;
      end
      if (enc_multi) begin
         error_d = 1'b1;
      end
   end

   // State registers; clear zeroes everything immediately.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            reg_file_q[i] <= '0;
         end
         last_sel_q <= '0;
         error_q    <= 1'b0;
      end else begin
         reg_file_q <= reg_file_d;
         last_sel_q <= last_sel_d;
         error_q    <= error_d;
      end
   end

   // Flatten the register file for the mux; slot 0 reads zero in base-address mode.
   always_comb begin
      regs_q = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         regs_q[i*WIDTH +: WIDTH] = reg_file_q[i];
      end
      regs_q[R0_IDX*WIDTH +: WIDTH] = reg_file_q[R0_IDX] & ~{WIDTH{ba_out}};
   end

   // Live select when requested, otherwise hold the last valid index.
   always_comb begin
      select_valid = enc_valid;
      select       = enc_valid ? enc_sel : last_sel_q;
      select_error = error_q;
   end

endmodule : gp_register_bank

// File: tb/tb_gp_register_bank.sv
// Directed self-checking bench for gp_register_bank.
module tb_gp_register_bank;

   logic          clock;
   logic          clear;
   logic [31:0]   bus_in;
   logic [15:0]   reg_in;
   logic [15:0]   reg_out;
   logic          ba_out;
   logic [511:0]  regs_q;
   logic [3:0]    select;
   logic          select_valid;
   logic          select_error;

   int unsigned n_vec;
   int unsigned n_miscompare;

   gp_register_bank dut (
      .clock        (clock),
      .clear        (clear),
      .bus_in       (bus_in),
      .reg_in       (reg_in),
      .reg_out      (reg_out),
      .ba_out       (ba_out),
      .regs_q       (regs_q),
      .select       (select),
      .select_valid (select_valid),
      .select_error (select_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      n_vec++;
      if (obs !== exp_val) begin
         n_miscompare++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_val);
      end
   endtask

   function automatic logic [31:0] slot(input int i);
      return regs_q[i*32 +: 32];
   endfunction

   // Advance past one rising edge; inputs change 1ns after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_vec        = 0;
      n_miscompare = 0;
      clear   = 1'b1;
      bus_in  = '0;
      reg_in  = '0;
      reg_out = '0;
      ba_out  = 1'b0;
      #23;
      // Reset state
      for (int i = 0; i < 16; i++) check_vec($sformatf("rst_slot%0d", i), slot(i), 32'h0);
      check_vec("rst_select", 32'(select), 32'd0);
      check_vec("rst_valid", 32'(select_valid), 32'd0);
      check_vec("rst_error", 32'(select_error), 32'd0);
      clear = 1'b0;
      tick();

      // Load R3
      bus_in = 32'hDEADBEEF; reg_in = 16'h0008;
      tick();
      reg_in = '0; #1;
      check_vec("load_r3", slot(3), 32'hDEADBEEF);
      check_vec("load_r2_untouched", slot(2), 32'h0);
      reg_out = 16'h0008; #1;
      check_vec("sel_r3", 32'(select), 32'd3);
      check_vec("valid_r3", 32'(select_valid), 32'd1);

      // Transfer R3 -> R5 in a single cycle
      bus_in = 32'hDEADBEEF; reg_in = 16'h0020;
      tick();
      reg_in = '0; reg_out = '0; #1;
      check_vec("xfer_r5", slot(5), 32'hDEADBEEF);
      check_vec("hold_sel3", 32'(select), 32'd3);
      check_vec("hold_valid0", 32'(select_valid), 32'd0);

      // Broadcast into R0 and R15
      bus_in = 32'h12345678; reg_in = 16'h8001;
      tick();
      reg_in = '0; #1;
      check_vec("bcast_r0", slot(0), 32'h12345678);
      check_vec("bcast_r15", slot(15), 32'h12345678);
      check_vec("bcast_r3_kept", slot(3), 32'hDEADBEEF);
      check_vec("bcast_hold_sel", 32'(select), 32'd3);

      // Base-address gating of slot 0 only
      ba_out = 1'b1; #1;
      check_vec("ba_slot0_zero", slot(0), 32'h0);
      check_vec("ba_slot15_kept", slot(15), 32'h12345678);
      tick();
      ba_out = 1'b0; #1;
      check_vec("ba_off_slot0", slot(0), 32'h12345678);

      // Highest and lowest index selects with hold
      reg_out = 16'h8000; #1;
      check_vec("sel_r15", 32'(select), 32'd15);
      tick();
      reg_out = '0; #1;
      check_vec("hold_sel15", 32'(select), 32'd15);
      reg_out = 16'h0001; #1;
      check_vec("sel_r0", 32'(select), 32'd0);
      check_vec("valid_r0", 32'(select_valid), 32'd1);

      // Self-transfer on R3
      reg_out = 16'h0008; reg_in = 16'h0008; bus_in = 32'hDEADBEEF;
      tick();
      reg_in = '0; reg_out = '0; #1;
      check_vec("self_xfer_r3", slot(3), 32'hDEADBEEF);
      check_vec("no_error_yet", 32'(select_error), 32'd0);

      // Conflict: lowest index wins, error is sticky
      reg_out = 16'h0024; #1;
      check_vec("conf_sel", 32'(select), 32'd2);
      check_vec("conf_valid", 32'(select_valid), 32'd1);
      check_vec("conf_err_pre_edge", 32'(select_error), 32'd0);
      tick();
      reg_out = '0; #1;
      check_vec("conf_err_set", 32'(select_error), 32'd1);
      check_vec("conf_hold_sel2", 32'(select), 32'd2);
      tick(); tick();
      check_vec("conf_err_sticky", 32'(select_error), 32'd1);

      // Clear mid-cycle with an in-flight load
      bus_in = 32'hAAAA5555; reg_in = 16'hFFFF; #2;
      clear = 1'b1; #1;
      check_vec("clr_slot0", slot(0), 32'h0);
      check_vec("clr_slot3", slot(3), 32'h0);
      check_vec("clr_slot15", slot(15), 32'h0);
      check_vec("clr_select", 32'(select), 32'd0);
      check_vec("clr_error", 32'(select_error), 32'd0);
      tick();
      check_vec("clr_load_lost", slot(7), 32'h0);
      reg_in = '0; #1;
      clear = 1'b0;

      // First load after release
      bus_in = 32'h0BADF00D; reg_in = 16'h0002;
      tick();
      reg_in = '0; #1;
      check_vec("post_clr_r1", slot(1), 32'h0BADF00D);
      check_vec("post_clr_r2", slot(2), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule : tb_gp_register_bank
